// File: rtl/microcore_sequencer.sv
// Schedule-bus sequencer for a bank of SHA-256d microcores, plus golden-nonce collection.
// Optional GNONCE_FIFO_EN: 4-deep golden nonce FIFO instead of a single holding register.
`timescale 1ns/1ps
module microcore_sequencer #(
    parameter int NUM_CORES = 4,
    parameter int CYCLE_LEN = 67
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [255:0]         job_midstate,
    input  logic [95:0]          job_data,
    input  logic [31:0]          job_nonce,
    output logic [7:0]           cnt,
    output logic                 pass,
    output logic [255:0]         midstate,
    output logic [31:0]          m7,
    output logic [31:0]          k_in,
    output logic [31:0]          r1_in,
    input  logic [NUM_CORES-1:0] gnon,
    output logic                 golden_valid,
    input  logic                 golden_ready,
    output logic [31:0]          golden_nonce,
    output logic                 golden_drop,
    output logic                 busy,
    output logic                 exhausted
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [7:0]   LAST_CNT = 8'(CYCLE_LEN - 1);
    localparam logic [255:0] SHA_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         pass_q, pass_d, primed_q, primed_d, exh_q, exh_d, ready_q, drop_q;
    logic [31:0]  base_q, base_d, prev_base_q, prev_base_d;
    logic [31:0]  k_q, k_d, r1_q, r1_d, m7_q;
    logic [255:0] mid_q, mid_d, jmid_q;
    logic [95:0]  jdata_q, data_src;
    logic [32:0]  base_sum;
    logic         accept, sample, hit, multi, pop, push, lost, gv;
    logic [31:0]  hit_off, hit_nonce, gn;

    assign accept   = job_valid & ready_q;
    assign data_src = accept ? job_data : jdata_q;
    assign base_sum = {1'b0, base_q} + 33'(NUM_CORES);

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; pass_d = pass_q; base_d = base_q;
        prev_base_d = prev_base_q; primed_d = primed_q; exh_d = exh_q;
        if (accept) begin
            state_d = RUN; cnt_d = '0; pass_d = 1'b0; base_d = job_nonce; primed_d = 1'b0; exh_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d  = '0;
                        pass_d = ~pass_q;
                        if (pass_q) begin
                            prev_base_d = base_q;
                            base_d      = base_sum[31:0];
                            primed_d    = 1'b1;
                            if (base_sum[32]) begin
                                state_d = DRAIN;
                                exh_d   = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (cnt_q == 8'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus words are derived from the next cnt/pass so they land on the same edge.
    always_comb begin
        k_d = '0; r1_d = '0; mid_d = mid_q;
        if (state_d != IDLE) begin
            if (cnt_d < 8'd64) k_d = K[cnt_d[5:0]];
            mid_d = pass_d ? SHA_IV : (accept ? job_midstate : jmid_q);
            if (!pass_d) begin
                case (cnt_d)
                    8'd0:    r1_d = data_src[31:0];
                    8'd1:    r1_d = data_src[63:32];
                    8'd2:    r1_d = data_src[95:64];
                    8'd3:    r1_d = base_d;
                    8'd4:    r1_d = 32'h8000_0000;
                    8'd15:   r1_d = 32'h0000_0280;
                    default: r1_d = '0;
                endcase
            end else begin
                case (cnt_d)
                    8'd8:    r1_d = 32'h8000_0000;
                    8'd15:   r1_d = 32'h0000_0100;
                    default: r1_d = '0;
                endcase
            end
        end
    end

    always_comb begin
        hit_off = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (gnon[i]) hit_off = 32'(i);
        end
    end

    assign sample    = (state_q != IDLE) && !pass_q && (cnt_q == 8'd1) && primed_q;
    assign hit       = sample && (gnon != '0);
    assign multi     = sample && ($countones(gnon) > 1);
    assign hit_nonce = prev_base_q + hit_off;
    assign lost      = (hit & ~push) | multi;

`ifdef GNONCE_FIFO_EN
    logic [31:0] fifo_q [4];
    logic [1:0]  wr_q, rd_q;
    logic [2:0]  count_q;

    assign pop  = (count_q != 3'd0) & golden_ready;
    assign push = hit & ((count_q != 3'd4) | pop);
    assign gv   = count_q != 3'd0;
    assign gn   = fifo_q[rd_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_q <= '0; rd_q <= '0; count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= hit_nonce;
                wr_q         <= wr_q + 2'd1;
            end
            if (pop) rd_q <= rd_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end
`else
    logic        gv_q;
    logic [31:0] gn_q;

    assign pop  = gv_q & golden_ready;
    assign push = hit & (~gv_q | pop);
    assign gv   = gv_q;
    assign gn   = gn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gv_q <= 1'b0;
            gn_q <= '0;
        end else begin
            if (push) gn_q <= hit_nonce;
            gv_q <= push | (gv_q & ~pop);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE; cnt_q <= '0; pass_q <= 1'b0; base_q <= '0; prev_base_q <= '0;
            primed_q <= 1'b0; exh_q <= 1'b0; ready_q <= 1'b0; drop_q <= 1'b0;
            k_q <= '0; r1_q <= '0; mid_q <= '0; m7_q <= '0; jmid_q <= '0; jdata_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; pass_q <= pass_d; base_q <= base_d;
            prev_base_q <= prev_base_d; primed_q <= primed_d; exh_q <= exh_d; ready_q <= 1'b1;
            k_q <= k_d; r1_q <= r1_d; mid_q <= mid_d;
            if (lost) drop_q <= 1'b1;
            if (accept) begin
                jmid_q  <= job_midstate;
                jdata_q <= job_data;
                m7_q    <= job_midstate[31:0];
            end
        end
    end

    assign job_ready    = ready_q;
    assign cnt          = cnt_q;
    assign pass         = pass_q;
    assign midstate     = mid_q;
    assign m7           = m7_q;
    assign k_in         = k_q;
    assign r1_in        = r1_q;
    assign golden_valid = gv;
    assign golden_nonce = gn;
    assign golden_drop  = drop_q;
    assign busy         = state_q != IDLE;
    assign exhausted    = exh_q;
endmodule

// File: tb/tb_microcore_sequencer.sv
// Randomised bench for microcore_sequencer: schedule bus predicted from cycle index since job load,
// golden nonces predicted into a scoreboard queue and popped by the monitor on handshake.
`timescale 1ns/1ps
module tb_microcore_sequencer;
    localparam int     NC   = 4;
    localparam int     CL   = 67;
    localparam longint PAIR = 2 * CL;
`ifdef GNONCE_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0, reset = 1'b1, job_valid = 1'b0, golden_ready = 1'b1;
    logic [255:0]  job_midstate = '0;
    logic [95:0]   job_data = '0;
    logic [31:0]   job_nonce = '0;
    logic [NC-1:0] gnon = '0;
    logic          job_ready, pass, golden_valid, golden_drop, busy, exhausted;
    logic [7:0]    cnt;
    logic [255:0]  midstate;
    logic [31:0]   m7, k_in, r1_in, golden_nonce;

    always #5 clk = ~clk;

    microcore_sequencer #(.NUM_CORES(NC), .CYCLE_LEN(CL)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_midstate(job_midstate), .job_data(job_data), .job_nonce(job_nonce),
        .cnt(cnt), .pass(pass), .midstate(midstate), .m7(m7), .k_in(k_in), .r1_in(r1_in),
        .gnon(gnon), .golden_valid(golden_valid), .golden_ready(golden_ready),
        .golden_nonce(golden_nonce), .golden_drop(golden_drop), .busy(busy), .exhausted(exhausted));

    logic [31:0]  kt [64];
    logic [255:0] ivt;
    int vectors = 0, errors = 0;

    bit           m_active = 0, m_ready = 0, m_drop = 0;
    longint       m_n = 0, m_end = 0;
    logic [31:0]  m_nonce = '0;
    logic [95:0]  m_data = '0;
    logic [255:0] m_mid = '0;
    logic [31:0]  exp_q [$];

    int gmode = 0, rmode = 0;
    logic [NC-1:0] gforce = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SHA-256 constants from first principles: fractional bits of cube/square roots of primes.
    initial begin
        int primes [64];
        int np;
        real r;
        np = 0;
        for (int c = 2; np < 64; c++) begin
            bit isp;
            isp = 1;
            for (int d = 2; d * d <= c; d++) if (c % d == 0) isp = 0;
            if (isp) begin primes[np] = c; np++; end
        end
        for (int i = 0; i < 64; i++) begin
            r = $pow(real'(primes[i]), 1.0 / 3.0);
            r = r - $floor(r);
            kt[i] = 32'(longint'($floor(r * 4294967296.0)));
        end
        for (int i = 0; i < 8; i++) begin
            r = $sqrt(real'(primes[i]));
            r = r - $floor(r);
            ivt[32*i +: 32] = 32'(longint'($floor(r * 4294967296.0)));
        end
    end

    // Reference model: advances at each clock edge from the inputs the bench drove.
    always @(posedge clk) begin
        int lo, ones;
        longint rem;
        logic [31:0] pb;
        if (reset) begin
            m_active = 0; m_ready = 0; m_drop = 0; m_n = 0;
            exp_q.delete();
        end else begin
            if (m_active && m_n >= PAIR && m_n <= m_end + 1 && (m_n % PAIR) == 1 && gnon != '0) begin
                lo = 0;
                for (int i = NC - 1; i >= 0; i--) if (gnon[i]) lo = i;
                ones = $countones(gnon);
                pb = m_nonce + 32'(longint'(NC) * (m_n / PAIR - 1));
                if (exp_q.size() < CAP) exp_q.push_back(pb + 32'(lo));
                else m_drop = 1;
                if (ones > 1) m_drop = 1;
            end
            if (job_valid && m_ready) begin
                m_active = 1; m_n = 0;
                m_nonce = job_nonce; m_data = job_data; m_mid = job_midstate;
                rem = 64'h1_0000_0000 - {32'h0, job_nonce};
                m_end = PAIR * ((rem + NC - 1) / NC);
            end else if (m_active) begin
                m_n++;
            end
            m_ready = 1;
        end
    end

    // Monitor: compares every cycle on the falling edge and pops the scoreboard on handshake.
    always @(negedge clk) begin
        logic [7:0]   ec;
        logic         ep, eb, ex;
        logic [31:0]  ek, er, eba, e7;
        logic [255:0] em;
        longint       w;
        if (reset) begin
            check("rst_sched", {cnt, pass, k_in, r1_in}, '0);
            check("rst_mid", midstate, '0);
            check("rst_m7", m7, '0);
            check("rst_status", {busy, exhausted, job_ready, golden_valid, golden_drop}, '0);
            check("rst_gnonce", golden_nonce, '0);
        end else begin
            ec = '0; ep = 0; eb = 0; ex = 0; eba = '0; em = '0; e7 = '0;
            if (m_active) begin
                em = m_mid; e7 = m_mid[31:0];
                if (m_n < m_end) begin
                    w = m_n % PAIR;
                    ep = (w >= CL);
                    ec = 8'(w % CL);
                    eba = m_nonce + 32'(longint'(NC) * (m_n / PAIR));
                    eb = 1;
                end else if (m_n < m_end + 2) begin
                    ec = 8'(m_n - m_end);
                    eb = 1; ex = 1;
                end else begin
                    ex = 1;
                end
                if (ep) em = ivt;
            end
            ek = (eb && ec < 8'd64) ? kt[ec[5:0]] : 32'h0;
            er = '0;
            if (eb && !ep) begin
                case (ec)
                    8'd0: er = m_data[31:0];
                    8'd1: er = m_data[63:32];
                    8'd2: er = m_data[95:64];
                    8'd3: er = eba;
                    8'd4: er = 32'h8000_0000;
                    8'd15: er = 32'h0000_0280;
                    default: er = '0;
                endcase
            end else if (eb) begin
                case (ec)
                    8'd8: er = 32'h8000_0000;
                    8'd15: er = 32'h0000_0100;
                    default: er = '0;
                endcase
            end
            check("sched", {cnt, pass, k_in, r1_in}, {ec, ep, ek, er});
            check("midstate", midstate, em);
            check("m7", m7, e7);
            check("status", {busy, exhausted, job_ready}, {eb, ex, m_ready});
            check("golden_valid", golden_valid, exp_q.size() > 0);
            check("golden_drop", golden_drop, m_drop);
            if (exp_q.size() > 0 && golden_ready) check("golden_nonce", golden_nonce, exp_q.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        case (gmode)
            0: gnon = '0;
            1: gnon = gforce;
            default: gnon = NC'($urandom_range(0, (1 << NC) - 1));
        endcase
        case (rmode)
            0: golden_ready = 1'b1;
            1: golden_ready = 1'b0;
            default: golden_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic load_job(input logic [31:0] nonce);
        @(posedge clk); #1;
        job_valid = 1'b1;
        job_nonce = nonce;
        job_data  = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) job_midstate[32*i +: 32] = $urandom;
        @(posedge clk); #1;
        job_valid = 1'b0;
        job_nonce = $urandom;
        job_data  = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) job_midstate[32*i +: 32] = $urandom;
    endtask

    initial begin
        cycles(3); #1 reset = 1'b0;

        load_job(32'h100);
        cycles(3 * 134 + 10);

        gmode = 1; gforce = 4'b0100;
        load_job(32'h0);
        cycles(134 + 20);
        rmode = 1; gforce = 4'b0001;
        cycles(2 * 134);
        rmode = 0; gmode = 0;
        cycles(10);

        @(posedge clk); #1 reset = 1'b1;
        cycles(2); #1 reset = 1'b0;
        gmode = 1; gforce = 4'b0101;
        load_job($urandom);
        cycles(2 * 134 + 10);

        gmode = 2; rmode = 2;
        load_job($urandom);
        cycles(300);
        load_job($urandom);
        cycles(300);

        gmode = 1; gforce = 4'b0010; rmode = 0;
        load_job(32'hFFFF_FFFC);
        cycles(160);
        gmode = 2; rmode = 2;
        load_job(32'hFFFF_FFF4);
        cycles(3 * 134 + 20);
        rmode = 0; gmode = 0;
        cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
